user_word_seq: RTL
==================

USER_WORD_SEQ -- requirements
Module: user_word_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning cycles to wait for i_word_ready per word before abort.
REQ-002 The block SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port i_start  input  1  request to start one user-word sequence.
REQ-005 The block SHALL have port i_is_su_mode  input  1  supervisor mode; highest priority.
REQ-006 The block SHALL have port i_is_em_emul  input  1  EM emulation mode.
REQ-007 The block SHALL have port i_is_ata_emul  input  1  ATA emulation mode.
REQ-008 The block SHALL have port i_page  input  1  page select.
REQ-009 The block SHALL have port i_cfg  input  7  configuration word.
REQ-010 The block SHALL have port i_word_ready  input  1  downstream accepts the current word.
REQ-011 The block SHALL have port i_abort  input  1  cancel the active sequence.
REQ-012 The block SHALL have port o_word_valid  output  1  word index presented.
REQ-013 The block SHALL have port o_word_idx  output  4  index of the current word, 0-based.
REQ-014 The block SHALL have port o_word_cnt  output  4  latched word count of the active or last sequence.
REQ-015 The block SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-016 The block SHALL have port o_done  output  1  one-cycle pulse on normal completion.
REQ-017 The block SHALL have port o_err  output  1  one-cycle pulse on timeout or abort.

Function
REQ-018 Count mapping SHALL use priority su > em > ata > none.
- su: 0.
- em: i_cfg[3:0] 5..13 gives i_cfg[3:0]-5; any other value gives 3.
- ata: i_cfg[6:4] 0/1 gives 0; 2 gives 1; 3 gives 2; 4..7 gives 2 if i_page, else i_cfg[6:4]-1.
- none: 0.
REQ-019 FSM states SHALL be IDLE, LOAD, XFER, FIN.
REQ-020 In IDLE, i_start SHALL latch mode, page, cfg and the mapped count; the FSM goes to LOAD next cycle. i_start is ignored in every other state.
REQ-021 LOAD SHALL last one cycle. It drives o_word_cnt from the latched count, clears the index, then goes to FIN if the count is 0, else XFER.
REQ-022 In XFER, o_word_valid SHALL be 1 and o_word_idx SHALL hold steady until a handshake (o_word_valid & i_word_ready).
REQ-023 On a handshake, idx SHALL increment and the timeout counter SHALL clear. A handshake on the last word (idx == count-1) goes to FIN.
REQ-024 The timeout counter SHALL increment each XFER cycle without a handshake. Reaching TIMEOUT_CYC-1 without a handshake pulses o_err and returns to IDLE.
REQ-025 i_abort in LOAD or XFER SHALL pulse o_err next cycle and return to IDLE. If abort and handshake coincide, abort wins and o_done is not asserted.
REQ-026 FIN SHALL pulse o_done for one cycle, then return to IDLE. A new sequence may start from the next IDLE cycle, so start-to-start spacing is at least count+3 cycles.
REQ-027 Input changes after the latch SHALL NOT affect the active sequence.
REQ-028 Start-to-first-valid latency SHALL be 2 cycles (start in cycle N, valid in cycle N+2).

Reset
REQ-029 On i_rst:
- the FSM SHALL go to IDLE, with o_word_valid=0, o_word_idx=0, o_word_cnt=0, o_busy=0, o_done=0, o_err=0;
- all latched fields and counters SHALL clear.
REQ-030 Reset mid-XFER SHALL drop o_word_valid the cycle after the reset edge, with no o_done or o_err pulse.

Structure
REQ-031 A shared package user_word_pkg SHALL hold the state enum, the mode enum (SU/EM/ATA/NONE) and the 4-bit count type.
REQ-032 The count mapping SHALL be one combinational sub-module, user_word_cnt_calc, instantiated once on the latched fields; the FSM and counters live in user_word_seq.

Verification
REQ-033 su=1, start, ready tied 1 -> no o_word_valid; o_done 3 cycles after start; o_word_cnt=0.
REQ-034 em=1, cfg=7'h06, start, ready=1 -> one word, idx 0; o_word_cnt=1; o_done after the handshake.
REQ-035 ata=1, cfg=7'h60, page=0, ready toggling 1/0 -> idx 0..4 each held until accepted; o_word_cnt=5; o_done once. Repeat with page=1 -> o_word_cnt=2.
REQ-036 em=1, cfg=7'h0D, ready=0 for 16 cycles -> o_err pulse, o_busy=0, idx stuck at 0 until the error.
REQ-037 ata=1, cfg=7'h70, page=0, abort asserted with ready at idx 3 -> o_err, no o_done. A start issued during XFER is ignored.
REQ-038 Reset asserted at idx 2 of a 6-word sequence -> all outputs zero next cycle; a following start runs normally.

Source files
------------

// File: rtl/user_word_pkg.sv
// Shared types for the user-word sequencer: FSM states, latched access mode
// and the 4-bit word count used by both the mapper and the sequencer.
package user_word_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    MODE_SU,
    MODE_EM,
    MODE_ATA,
    MODE_NONE
  } mode_e;

  typedef logic [3:0] cnt_t;

  localparam int CFG_W = 7;

  // Supervisor beats EM emulation, which beats ATA emulation.
  function automatic mode_e pickMode(input logic su, input logic em, input logic ata);
    mode_e m;
    if (su)       m = MODE_SU;
    else if (em)  m = MODE_EM;
    else if (ata) m = MODE_ATA;
    else          m = MODE_NONE;
    return m;
  endfunction

endpackage

// File: rtl/user_word_if.sv
// Request/word handshake bundle between a requester and the user-word sequencer.
interface user_word_if;
  import user_word_pkg::*;

  logic             i_start;
  logic             i_is_su_mode;
  logic             i_is_em_emul;
  logic             i_is_ata_emul;
  logic             i_page;
  logic [CFG_W-1:0] i_cfg;
  logic             i_word_ready;
  logic             i_abort;
  logic             o_word_valid;
  cnt_t             o_word_idx;
  cnt_t             o_word_cnt;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  modport master (
    output i_start, i_is_su_mode, i_is_em_emul, i_is_ata_emul, i_page, i_cfg,
           i_word_ready, i_abort,
    input  o_word_valid, o_word_idx, o_word_cnt, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_is_su_mode, i_is_em_emul, i_is_ata_emul, i_page, i_cfg,
           i_word_ready, i_abort,
    output o_word_valid, o_word_idx, o_word_cnt, o_busy, o_done, o_err
  );

endinterface

// File: rtl/user_word_cnt_calc.sv
// Maps the latched mode, page and configuration word to the number of user
// words to transfer. Purely combinational.
module user_word_cnt_calc
  import user_word_pkg::*;
(
  input  mode_e            mode_i,
  input  logic             page_i,
  input  logic [CFG_W-1:0] cfg_i,
  output cnt_t             cnt_o
);

  // EM uses the low nibble with an offset of 5; out-of-window values fall back to 3.
  // ATA uses the high field; large fields are capped at 2 words on page 1.
  always_comb begin
    cnt_o = '0;
    case (mode_i)
      MODE_EM: begin
        if ((cfg_i[3:0] >= 4'd5) && (cfg_i[3:0] <= 4'd13)) cnt_o = cfg_i[3:0] - 4'd5;
        else                                               cnt_o = 4'd3;
      end
      MODE_ATA: begin
        case (cfg_i[6:4])
          3'd0, 3'd1: cnt_o = 4'd0;
          3'd2:       cnt_o = 4'd1;
          3'd3:       cnt_o = 4'd2;
          default:    cnt_o = page_i ? 4'd2 : {1'b0, cfg_i[6:4] - 3'd1};
        endcase
      end
      default: cnt_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/user_word_seq.sv
// User-word sequencer: latches a request, presents word indices one at a time
// under a ready handshake, and finishes with a done or error pulse.
module user_word_seq #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  user_word_if.slave  bus
);
  import user_word_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_q;
  mode_e            mode_q;
  logic             page_q;
  logic [CFG_W-1:0] cfg_q;
  cnt_t             wordCnt_q;
  cnt_t             wordIdx_q;
  logic [TMO_W-1:0] tmoCnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  cnt_t             calcCnt;
  logic             handshake;

  user_word_cnt_calc u_cnt_calc (
    .mode_i (mode_q),
    .page_i (page_q),
    .cfg_i  (cfg_q),
    .cnt_o  (calcCnt)
  );

  assign handshake = valid_q & bus.i_word_ready;

  // Request fields are captured only in IDLE, so later input changes cannot
  // disturb a running sequence; the count is resolved from them in LOAD.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_NONE;
      page_q    <= 1'b0;
      cfg_q     <= '0;
      wordCnt_q <= '0;
      wordIdx_q <= '0;
      tmoCnt_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            mode_q  <= pickMode(bus.i_is_su_mode, bus.i_is_em_emul, bus.i_is_ata_emul);
            page_q  <= bus.i_page;
            cfg_q   <= bus.i_cfg;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.i_abort) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wordCnt_q <= calcCnt;
            wordIdx_q <= '0;
            tmoCnt_q  <= '0;
            if (calcCnt == '0) begin
              state_q <= ST_FIN;
            end else begin
              valid_q <= 1'b1;
              state_q <= ST_XFER;
            end
          end
        end
        // Abort takes precedence over a coinciding handshake.
        ST_XFER: begin
          if (bus.i_abort) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (handshake) begin
            tmoCnt_q  <= '0;
            wordIdx_q <= wordIdx_q + 4'd1;
            if (wordIdx_q == wordCnt_q - 4'd1) begin
              valid_q <= 1'b0;
              state_q <= ST_FIN;
            end
          end else if (tmoCnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmoCnt_q <= tmoCnt_q + 1'b1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_word_valid = valid_q;
  assign bus.o_word_idx   = wordIdx_q;
  assign bus.o_word_cnt   = wordCnt_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_err        = err_q;

endmodule
